// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder: FSM encoding, default width and
// the counter-width helper used to size the bit counter.
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_CNT_W = $clog2(DEF_WIDTH);

    // Counter must index bits 0..w-1; never narrower than one bit.
    function automatic int cnt_width(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/serial_adder_ctrl_fa_cell.sv
// Single-bit full adder cell, purely combinational; the serial adder time-shares it
// across all operand bits.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: sequences operand bits LSB-first through one fa_cell,
// feeding carry back through a flip-flop, with a start/busy/done handshake.
module serial_adder_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow,
    output logic             busy,
    output logic             done
);

    localparam int                CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic             carry;
    logic             cell_s;
    logic             cell_co;
    logic             accept;
    logic             last_bit;

    fa_cell u_fa_cell (
        .a  (a_sr[0]),
        .b  (b_sr[0]),
        .ci (carry),
        .s  (cell_s),
        .co (cell_co)
    );

    // A start request arriving while bits are in flight is dropped, not queued.
    assign accept   = start && ((state == IDLE) || (state == DONE));
    assign last_bit = (state == SHIFT) && (cnt == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = SHIFT;
            end
            SHIFT: begin
                busy = 1'b1;
                if (cnt == CNT_LAST) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = start ? SHIFT : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Result registers are only overwritten by shifting, so the previous result
    // stays visible until the first bit of a new addition lands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            a_sr     <= '0;
            b_sr     <= '0;
            carry    <= 1'b0;
            sum      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else if (accept) begin
            cnt   <= '0;
            a_sr  <= a;
            b_sr  <= b;
            carry <= cin;
        end else if (state == SHIFT) begin
            sum   <= {cell_s, sum[WIDTH-1:1]};
            a_sr  <= a_sr >> 1;
            b_sr  <= b_sr >> 1;
            carry <= cell_co;
            cnt   <= cnt + CNT_W'(1);
            if (last_bit) begin
                cout     <= cell_co;
                overflow <= carry ^ cell_co;
            end
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl at WIDTH=8 and WIDTH=3, with a per-instance
// scoreboard of expected {cout,sum,overflow} checked whenever done pulses.
module tb_serial_adder_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       st8 = 1'b0, ci8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic [7:0] sum8;
    logic       co8, ov8, busy8, done8;

    logic       st3 = 1'b0, ci3 = 1'b0;
    logic [2:0] a3 = '0, b3 = '0;
    logic [2:0] sum3;
    logic       co3, ov3, busy3, done3;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct packed {
        logic [8:0] res;
        logic       ovf;
    } exp_t;

    exp_t q8[$];
    exp_t q3[$];

    always #5 clk = ~clk;

    serial_adder_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(st8), .a(a8), .b(b8), .cin(ci8),
        .sum(sum8), .cout(co8), .overflow(ov8), .busy(busy8), .done(done8)
    );

    serial_adder_ctrl #(.WIDTH(3)) dut3 (
        .clk(clk), .rst(rst), .start(st3), .a(a3), .b(b3), .cin(ci3),
        .sum(sum3), .cout(co3), .overflow(ov3), .busy(busy3), .done(done3)
    );

    function automatic exp_t model(input int w, input int a, input int b, input int c);
        exp_t e;
        int   sa, sb, ss;
        e.res = 9'(a + b + c);
        sa    = (a >= (1 << (w - 1))) ? a - (1 << w) : a;
        sb    = (b >= (1 << (w - 1))) ? b - (1 << w) : b;
        ss    = sa + sb + c;
        e.ovf = (ss > (1 << (w - 1)) - 1) || (ss < -(1 << (w - 1)));
        return e;
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitors: compare on every done pulse.
    always @(negedge clk) begin
        if (!rst && done8) begin
            chk("busy_with_done8", busy8, 0);
            if (q8.size() == 0) begin
                chk("unexpected_done8", done8, 0);
            end else begin
                exp_t e;
                e = q8.pop_front();
                chk("sum8", sum8, e.res[7:0]);
                chk("cout8", co8, e.res[8]);
                chk("ovf8", ov8, e.ovf);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && done3) begin
            chk("busy_with_done3", busy3, 0);
            if (q3.size() == 0) begin
                chk("unexpected_done3", done3, 0);
            end else begin
                exp_t e;
                e = q3.pop_front();
                chk("cout_sum3", {co3, sum3}, e.res[3:0]);
                chk("ovf3", ov3, e.ovf);
            end
        end
    end

    // Pulse start for one cycle; returns at the negedge after the accepting edge.
    task automatic launch8(input int a, input int b, input int c);
        @(negedge clk);
        st8 = 1'b1; a8 = 8'(a); b8 = 8'(b); ci8 = c[0];
        q8.push_back(model(8, a, b, c));
        @(negedge clk);
        st8 = 1'b0;
    endtask

    // Counts busy cycles until done; returns positioned at the done negedge.
    task automatic wait8(output int nb);
        bit seen;
        nb   = 0;
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            if (done8) begin
                seen = 1;
                break;
            end
            if (busy8) nb++;
            @(negedge clk);
        end
        if (!seen) chk("timeout8", 0, 1);
    endtask

    task automatic run3(input int a, input int b, input int c);
        bit seen;
        @(negedge clk);
        st3 = 1'b1; a3 = 3'(a); b3 = 3'(b); ci3 = c[0];
        q3.push_back(model(3, a, b, c));
        @(negedge clk);
        st3  = 1'b0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (done3) begin
                seen = 1;
                break;
            end
            @(negedge clk);
        end
        if (!seen) chk("timeout3", 0, 1);
    endtask

    initial begin
        int nb;
        int ndone;

        // Reset, then idle
        #12 rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_sum", sum8, 0);
        chk("rst_cout", co8, 0);
        chk("rst_ovf", ov8, 0);
        chk("rst_busy", busy8, 0);
        chk("rst_done", done8, 0);

        // Basic add with latency and hold
        launch8(8'h5A, 8'h3C, 0);
        wait8(nb);
        chk("latency_5a3c", nb, 8);
        @(negedge clk);
        chk("hold_sum", sum8, 8'h96);
        chk("done_pulse_width", done8, 0);

        launch8(8'hFF, 8'h01, 0);
        wait8(nb);
        launch8(8'h00, 8'h00, 1);
        wait8(nb);

        // Start during SHIFT ignored; start held in DONE chains directly
        launch8(8'h0F, 8'h01, 0);
        repeat (3) @(negedge clk);
        st8 = 1'b1; a8 = 8'h11;
        @(negedge clk);
        st8 = 1'b0;
        wait8(nb);
        st8 = 1'b1; a8 = 8'h20; b8 = 8'h22; ci8 = 1'b1;
        q8.push_back(model(8, 8'h20, 8'h22, 1));
        @(negedge clk);
        st8 = 1'b0;
        chk("chain_busy", busy8, 1);
        chk("chain_done", done8, 0);
        wait8(nb);
        chk("latency_chain", nb, 8);

        // Asynchronous reset mid-operation
        launch8(8'h5A, 8'h3C, 0);
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_sum", sum8, 0);
        chk("arst_cout", co8, 0);
        chk("arst_ovf", ov8, 0);
        chk("arst_busy", busy8, 0);
        chk("arst_done", done8, 0);
        q8.delete();
        #1 rst = 1'b0;
        ndone = 0;
        repeat (12) begin
            @(negedge clk);
            if (done8) ndone++;
        end
        chk("no_done_after_arst", ndone, 0);
        launch8(8'h7F, 8'h01, 0);
        wait8(nb);
        launch8(8'h80, 8'h80, 1);
        wait8(nb);
        @(negedge clk);

        // WIDTH=3 exhaustive
        for (int a = 0; a < 8; a++)
            for (int b = 0; b < 8; b++)
                for (int c = 0; c < 2; c++)
                    run3(a, b, c);
        @(negedge clk);
        chk("q8_drained", q8.size(), 0);
        chk("q3_drained", q3.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
